// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: sequences each instruction
// through fetch/decode/execute/memory/writeback and drives every datapath control.
module multicycle_ctrl #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    // ready_gate marks the states whose strobes only fire once memory completes.
    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       done;
        logic       ready_gate;
    } ctrl_t;

    function automatic ctrl_t outputs_for(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.memread    = 1'b1;
                c.alusrcb    = 2'b01;
                c.irwrite    = 1'b1;
                c.pcwrite    = 1'b1;
                c.ready_gate = 1'b1;
            end
            DECODE: c.alusrcb = 2'b11;
            MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            MEMRD: begin
                c.memread = 1'b1;
                c.iord    = 1'b1;
            end
            MEMWB: begin
                c.regwrite = 1'b1;
                c.memtoreg = 1'b1;
                c.done     = 1'b1;
            end
            MEMWR: begin
                c.memwrite   = 1'b1;
                c.iord       = 1'b1;
                c.done       = 1'b1;
                c.ready_gate = 1'b1;
            end
            EXEC: begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b10;
            end
            RWB: begin
                c.regwrite = 1'b1;
                c.regdst   = 1'b1;
                c.done     = 1'b1;
            end
            BRANCH: begin
                c.alusrca     = 1'b1;
                c.aluop       = 2'b01;
                c.pcwritecond = 1'b1;
                c.pcsrc       = 2'b01;
                c.done        = 1'b1;
            end
            ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            ADDIWB: begin
                c.regwrite = 1'b1;
                c.done     = 1'b1;
            end
            JUMP: begin
                c.pcwrite = 1'b1;
                c.pcsrc   = 2'b10;
                c.done    = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl_q;
    logic   supported;
    logic   run;
    logic   gate_ok;
    logic   bad_decode;

    always_comb begin
        supported = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
                    (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
                if ((op == OP_LW) || (op == OP_SW)) state_d = MEMADR;
                else if (op == OP_RTYPE)            state_d = EXEC;
                else if (op == OP_BEQ)              state_d = BRANCH;
                else if (op == OP_ADDI)             state_d = ADDIEX;
                else if (op == OP_J)                state_d = JUMP;
                else                                state_d = FETCH;
            end
            MEMADR: state_d = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  state_d = mem_ready ? MEMWB : MEMRD;
            MEMWB:  state_d = FETCH;
            MEMWR:  state_d = mem_ready ? FETCH : MEMWR;
            EXEC:   state_d = RWB;
            RWB:    state_d = FETCH;
            BRANCH: state_d = FETCH;
            ADDIEX: state_d = ADDIWB;
            ADDIWB: state_d = FETCH;
            JUMP:   state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // Control bits are registered alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            ctrl_q  <= outputs_for(FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= outputs_for(state_d);
        end
    end

    assign run        = ~reset;
    assign gate_ok    = ~ctrl_q.ready_gate | mem_ready;
    assign bad_decode = (state_q == DECODE) & ~supported;

    assign pcwrite     = run & ctrl_q.pcwrite & gate_ok;
    assign irwrite     = run & ctrl_q.irwrite & gate_ok;
    assign instr_done  = run & ((ctrl_q.done & gate_ok) | bad_decode);
    assign illegal_op  = run & bad_decode;
    assign pcwritecond = run & ctrl_q.pcwritecond;
    assign iord        = run & ctrl_q.iord;
    assign memread     = run & ctrl_q.memread;
    assign memwrite    = run & ctrl_q.memwrite;
    assign memtoreg    = run & ctrl_q.memtoreg;
    assign regdst      = run & ctrl_q.regdst;
    assign regwrite    = run & ctrl_q.regwrite;
    assign alusrca     = run & ctrl_q.alusrca;
    assign alusrcb     = {2{run}} & ctrl_q.alusrcb;
    assign aluop       = {2{run}} & ctrl_q.aluop;
    assign pcsrc       = {2{run}} & ctrl_q.pcsrc;
    assign state       = run ? state_q : 4'd0;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: each cycle pushes the expected control
// vector to a scoreboard and compares it against the DUT before the next edge.
module tb_multicycle_ctrl;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic       mem_ready;
    logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
    logic       memtoreg, regdst, regwrite, alusrca, instr_done, illegal_op;
    logic [1:0] alusrcb, aluop, pcsrc;
    logic [3:0] state;

    typedef struct packed {
        logic [3:0] st;
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       instr_done;
        logic       illegal_op;
    } vec_t;

    vec_t  exp_q[$];
    string tag_q[$];
    int    checks;
    int    failures;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
        .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
        .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc),
        .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-state control table; the bench names the state sequence explicitly.
    function automatic vec_t spec_vec(input int code, input bit rdy, input bit ill);
        vec_t v;
        v = '0;
        v.st = 4'(code);
        case (code)
            0:  begin v.memread = 1; v.alusrcb = 2'b01; v.irwrite = rdy; v.pcwrite = rdy; end
            1:  begin v.alusrcb = 2'b11; v.illegal_op = ill; v.instr_done = ill; end
            2:  begin v.alusrca = 1; v.alusrcb = 2'b10; end
            3:  begin v.memread = 1; v.iord = 1; end
            4:  begin v.regwrite = 1; v.memtoreg = 1; v.instr_done = 1; end
            5:  begin v.memwrite = 1; v.iord = 1; v.instr_done = rdy; end
            6:  begin v.alusrca = 1; v.aluop = 2'b10; end
            7:  begin v.regwrite = 1; v.regdst = 1; v.instr_done = 1; end
            8:  begin v.alusrca = 1; v.aluop = 2'b01; v.pcwritecond = 1; v.pcsrc = 2'b01; v.instr_done = 1; end
            9:  begin v.alusrca = 1; v.alusrcb = 2'b10; end
            10: begin v.regwrite = 1; v.instr_done = 1; end
            11: begin v.pcwrite = 1; v.pcsrc = 2'b10; v.instr_done = 1; end
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic checkOutput();
        vec_t  expv;
        vec_t  obs;
        string t;
        expv = exp_q.pop_front();
        t    = tag_q.pop_front();
        obs  = {state, pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
                memtoreg, regdst, regwrite, alusrca, alusrcb, aluop, pcsrc,
                instr_done, illegal_op};
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", t, obs, expv);
        end
    endtask

    task automatic applyStimulus(input bit rst, input logic [5:0] o, input bit rdy,
                                 input int code, input bit ill, input string tag);
        @(negedge clk);
        reset     = rst;
        op        = o;
        mem_ready = rdy;
        exp_q.push_back(rst ? vec_t'('0) : spec_vec(code, rdy, ill));
        tag_q.push_back(tag);
        #2;
        checkOutput();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        op        = 6'b000000;
        mem_ready = 1'b1;

        applyStimulus(1, 6'b000000, 1, 0, 0, "reset_c0");
        applyStimulus(1, 6'b000000, 1, 0, 0, "reset_c1");
        applyStimulus(1, 6'b000000, 1, 0, 0, "reset_c2");

        // R-type, op changed after decode to show it is ignored
        applyStimulus(0, 6'b000000, 1, 0, 0, "rtype_fetch");
        applyStimulus(0, 6'b000000, 1, 1, 0, "rtype_decode");
        applyStimulus(0, 6'b111111, 1, 6, 0, "rtype_exec");
        applyStimulus(0, 6'b100011, 1, 7, 0, "rtype_wb");

        // lw with 2 fetch stalls and 3 read stalls
        applyStimulus(0, 6'b100011, 0, 0, 0, "lw_fetch_stall0");
        applyStimulus(0, 6'b100011, 0, 0, 0, "lw_fetch_stall1");
        applyStimulus(0, 6'b100011, 1, 0, 0, "lw_fetch_rdy");
        applyStimulus(0, 6'b100011, 1, 1, 0, "lw_decode");
        applyStimulus(0, 6'b100011, 1, 2, 0, "lw_memadr");
        applyStimulus(0, 6'b100011, 0, 3, 0, "lw_memrd_stall0");
        applyStimulus(0, 6'b100011, 0, 3, 0, "lw_memrd_stall1");
        applyStimulus(0, 6'b100011, 0, 3, 0, "lw_memrd_stall2");
        applyStimulus(0, 6'b100011, 1, 3, 0, "lw_memrd_rdy");
        applyStimulus(0, 6'b100011, 1, 4, 0, "lw_memwb");

        applyStimulus(0, 6'b000100, 1, 0, 0, "beq_fetch");
        applyStimulus(0, 6'b000100, 1, 1, 0, "beq_decode");
        applyStimulus(0, 6'b000100, 1, 8, 0, "beq_branch");

        applyStimulus(0, 6'b000010, 1, 0, 0, "j_fetch");
        applyStimulus(0, 6'b000010, 1, 1, 0, "j_decode");
        applyStimulus(0, 6'b000010, 1, 11, 0, "j_jump");
        applyStimulus(0, 6'b001000, 1, 0, 0, "addi_fetch");
        applyStimulus(0, 6'b001000, 1, 1, 0, "addi_decode");
        applyStimulus(0, 6'b001000, 1, 9, 0, "addi_ex");
        applyStimulus(0, 6'b001000, 1, 10, 0, "addi_wb");

        applyStimulus(0, 6'b111111, 1, 0, 0, "ill_fetch");
        applyStimulus(0, 6'b111111, 1, 1, 1, "ill_decode");

        // sw with one write stall
        applyStimulus(0, 6'b101011, 1, 0, 0, "sw_fetch");
        applyStimulus(0, 6'b101011, 1, 1, 0, "sw_decode");
        applyStimulus(0, 6'b101011, 1, 2, 0, "sw_memadr");
        applyStimulus(0, 6'b101011, 0, 5, 0, "sw_memwr_stall");
        applyStimulus(0, 6'b101011, 1, 5, 0, "sw_memwr_rdy");

        // sw aborted by reset while in MEMWR
        applyStimulus(0, 6'b101011, 1, 0, 0, "swrst_fetch");
        applyStimulus(0, 6'b101011, 1, 1, 0, "swrst_decode");
        applyStimulus(0, 6'b101011, 1, 2, 0, "swrst_memadr");
        applyStimulus(1, 6'b101011, 1, 5, 0, "swrst_abort");
        applyStimulus(0, 6'b000000, 1, 0, 0, "swrst_refetch");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
